// File: rtl/seq_dot_mac_pkg.sv
// Shared types and constants for the sequential dot-product MAC.
// Holds the FSM state enum, default sizes and the result width helper.
package seq_dot_mac_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int N_DEF      = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    DRAIN,
    OUT
  } state_t;

  function automatic int out_w(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/seq_dot_mac_abuf.sv
// N x DATA_W buffer for vector A: written in order, read by index.
// Ports: clk, we/waddr/wdata write side, raddr/rev/rdata read side.
module seq_dot_mac_abuf #(
  parameter int DATA_W = 16,
  parameter int N      = 16
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [$clog2(N)-1:0] waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic [$clog2(N)-1:0] raddr,
  input  logic                 rev,
  output logic [DATA_W-1:0]    rdata
);

  localparam int AW = $clog2(N);

  logic [DATA_W-1:0] mem [N];
  logic [AW-1:0]     ra;

  // Contents are always overwritten before being read, so no reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign ra    = rev ? (AW'(N - 1) - raddr) : raddr;
  assign rdata = mem[ra];

endmodule

// File: rtl/seq_dot_mac.sv
// Sequential dot product / reversed correlation of two N-word vectors.
// Ports: clk, rst_n, in_valid/in/in_mode stream in, out_valid/out result.
module seq_dot_mac
  import seq_dot_mac_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N      = N_DEF,
  parameter int OUT_W  = out_w(DATA_W, N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in,
  input  logic              in_mode,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out
);

  localparam int AW = $clog2(N);
  localparam int CW = AW + 1;
  localparam int PW = 2 * DATA_W;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic                    mode;
  logic [AW-1:0]           idx;
  logic [AW-1:0]           waddr;
  logic                    take;
  logic                    a_we;
  logic [DATA_W-1:0]       a_rd;
  logic signed [PW-1:0]    prod;
  logic                    prod_v;
  logic signed [OUT_W-1:0] acc;

  // Low counter bits index A while loading A and B while loading B.
  assign idx   = cnt[AW-1:0];
  assign waddr = (state == IDLE) ? '0 : idx;

  // In IDLE the cycle carrying out_valid must not start a burst.
  assign take = in_valid &
                (((state == IDLE) & ~out_valid) |
                 (state == LOAD_A) |
                 (state == LOAD_B));

  assign a_we = take & ((state == IDLE) | (state == LOAD_A));

  seq_dot_mac_abuf #(
    .DATA_W(DATA_W),
    .N     (N)
  ) u_abuf (
    .clk  (clk),
    .we   (a_we),
    .waddr(waddr),
    .wdata(in),
    .raddr(idx),
    .rev  (mode),
    .rdata(a_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mode      <= 1'b0;
      prod      <= '0;
      prod_v    <= 1'b0;
      acc       <= '0;
      out_valid <= 1'b0;
      out       <= '0;
    end else begin
      prod_v    <= 1'b0;
      out_valid <= 1'b0;
      out       <= '0;
      if (prod_v)
        acc <= acc + {{(OUT_W - PW){prod[PW-1]}}, prod};
      unique case (state)
        IDLE: begin
          if (take) begin
            mode  <= in_mode;
            cnt   <= CW'(1);
            acc   <= '0;
            state <= LOAD_A;
          end
        end
        LOAD_A: begin
          if (take) begin
            cnt <= cnt + CW'(1);
            if (idx == AW'(N - 1)) state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (take) begin
            prod   <= $signed(a_rd) * $signed(in);
            prod_v <= 1'b1;
            if (idx == AW'(N - 1)) begin
              cnt   <= '0;
              state <= DRAIN;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        // Two cycles: product lands, then the last accumulate.
        DRAIN: begin
          if (cnt[0]) begin
            cnt   <= '0;
            state <= OUT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        OUT: begin
          out_valid <= 1'b1;
          out       <= acc;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_dot_mac.sv
// Randomized self-checking bench for seq_dot_mac at DATA_W=16, N=16.
// Reference results come from a plain arithmetic sum over the vectors.
module tb_seq_dot_mac;

  localparam int DW = 16;
  localparam int NN = 16;
  localparam int OW = 36;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in = '0;
  logic          in_mode = 1'b0;
  logic          out_valid;
  logic [OW-1:0] out;

  int checks = 0;
  int errors = 0;
  int ov_cnt = 0;
  int va [NN];
  int vb [NN];

  seq_dot_mac #(
    .DATA_W(DW),
    .N     (NN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in       (in),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out      (out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid === 1'b1) ov_cnt++;
  end

  function automatic longint model(input bit m);
    longint s;
    s = 0;
    for (int i = 0; i < NN; i++)
      s += longint'(m ? va[NN-1-i] : va[i]) * longint'(vb[i]);
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_drive();
    in_valid = 1'b0;
    in       = DW'($urandom);
    in_mode  = 1'($urandom);
  endtask

  // Drives one burst (gap: 0 none, 1 alternate, 2 random), then checks
  // latency and value. hold keeps in_valid high through drain and output.
  task automatic run_burst(input string name, input bit m,
                           input int gap, input bit hold);
    logic [OW-1:0] ev;
    ev = OW'(model(m));
    for (int k = 0; k < 2 * NN; k++) begin
      if (gap == 1 && k > 0) begin
        idle_drive();
        step();
      end
      if (gap == 2) begin
        while ($urandom_range(0, 3) == 0) begin
          idle_drive();
          step();
        end
      end
      in_valid = 1'b1;
      in       = DW'(k < NN ? va[k] : vb[k-NN]);
      in_mode  = (k == 0) ? m : 1'($urandom);
      step();
    end
    for (int c = 0; c < 3; c++) begin
      in_valid = hold;
      in       = DW'($urandom);
      in_mode  = 1'($urandom);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s early_valid T+%0d: got %b want 0", name, c,
                 out_valid);
      end
      step();
    end
    checks++;
    if (out_valid !== 1'b1 || out !== ev) begin
      errors++;
      $display("FAIL %s result: got valid=%b out=%0d want valid=1 out=%0d",
               name, out_valid, $signed(out), $signed(ev));
    end
    in = DW'($urandom);
    step();
    checks++;
    if (out_valid !== 1'b0 || out !== '0) begin
      errors++;
      $display("FAIL %s after: got valid=%b out=%0d want 0 0", name,
               out_valid, $signed(out));
    end
    if (!hold) idle_drive();
  endtask

  task automatic load_ones_ramp();
    for (int i = 0; i < NN; i++) begin
      va[i] = 1;
      vb[i] = i + 1;
    end
  endtask

  task automatic load_ramp();
    for (int i = 0; i < NN; i++) begin
      va[i] = i;
      vb[i] = i;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_drive();
    step();
    checks++;
    if (out_valid !== 1'b0 || out !== '0) begin
      errors++;
      $display("FAIL reset: got valid=%b out=%0d want 0 0", out_valid, out);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_ones();
    load_ones_ramp();
    checks++;
    if (model(1'b0) != 136) begin
      errors++;
      $display("FAIL model_ones: got %0d want 136", model(1'b0));
    end
    run_burst("ones", 1'b0, 0, 1'b0);
  endtask

  task automatic test_min();
    for (int i = 0; i < NN; i++) begin
      va[i] = -32768;
      vb[i] = -32768;
    end
    run_burst("min", 1'b0, 0, 1'b0);
  endtask

  task automatic test_ramp();
    load_ramp();
    run_burst("ramp_m0", 1'b0, 0, 1'b0);
    run_burst("ramp_m1", 1'b1, 0, 1'b0);
  endtask

  task automatic test_gaps();
    load_ones_ramp();
    run_burst("gaps", 1'b0, 1, 1'b0);
  endtask

  task automatic test_reset_mid();
    int ov0;
    load_ones_ramp();
    for (int k = 0; k <= 10; k++) begin
      in_valid = 1'b1;
      in       = DW'(va[k]);
      in_mode  = 1'b0;
      step();
    end
    idle_drive();
    step();
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out !== '0) begin
      errors++;
      $display("FAIL reset_mid: got valid=%b out=%0d want 0 0",
               out_valid, out);
    end
    step();
    rst_n = 1'b1;
    step();
    ov0 = ov_cnt;
    for (int c = 0; c < 8; c++) step();
    run_burst("reset_mid", 1'b0, 0, 1'b0);
    step();
    checks++;
    if (ov_cnt - ov0 != 1) begin
      errors++;
      $display("FAIL reset_mid_count: got %0d pulses want 1", ov_cnt - ov0);
    end
  endtask

  task automatic test_back_to_back();
    load_ones_ramp();
    run_burst("b2b_first", 1'b0, 0, 1'b1);
    load_ramp();
    run_burst("b2b_second", 1'b1, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < NN; i++) begin
        va[i] = int'($urandom_range(0, 65535)) - 32768;
        vb[i] = int'($urandom_range(0, 65535)) - 32768;
      end
      run_burst("random", 1'($urandom), 2, 1'($urandom));
    end
    idle_drive();
    step();
  endtask

  initial begin
    test_reset();
    test_ones();
    test_min();
    test_ramp();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_dot_mac.md
SEQ_DOT_MAC -- requirements
Module: seq_dot_mac

Interface
REQ-001 Parameter DATA_W, default 16, signed input word width.
REQ-002 Parameter N, default 16, vector length (power of two, 2..64).
REQ-003 Parameter OUT_W, default 2*DATA_W+$clog2(N) (36 at defaults), signed result width.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  qualifies in and in_mode for the current cycle.
REQ-007 in  input  DATA_W  signed two's-complement operand word.
REQ-008 in_mode  input  1  operation select; sampled only with the first word of a burst.
REQ-009 out_valid  output  1  result strobe, high for exactly one cycle per completed burst.
REQ-010 out  output  OUT_W  signed result; zero whenever out_valid is low.

Function
REQ-011 A burst is 2N accepted words: words 0..N-1 form vector A, words N..2N-1 form vector B.
REQ-012 in_mode on the first accepted word is latched; in_mode on every other word is ignored.
REQ-013 Mode 0 result is sum over i of A[i]*B[i] (dot product).
REQ-014 Mode 1 result is sum over i of A[N-1-i]*B[i] (reversed-A correlation).
REQ-015 Products are full-precision signed 2*DATA_W; the accumulator is OUT_W wide and never overflows for any inputs.
REQ-016 States: IDLE, LOAD_A, LOAD_B, DRAIN, OUT.
REQ-017 IDLE -> LOAD_A on first accepted word; LOAD_A -> LOAD_B after word N-1; LOAD_B -> DRAIN after word 2N-1; DRAIN -> OUT after 2 cycles; OUT -> IDLE after 1 cycle.
REQ-018 Vector A is stored in an N-entry register buffer; B words are not stored but multiplied on arrival.
REQ-019 Multiply is registered one stage; accumulation is registered one stage.
REQ-020 Gaps allowed: in_valid low during LOAD_A/LOAD_B holds the word counter and accumulator unchanged.
REQ-021 Latency: if word 2N-1 is sampled at edge T, out_valid is high in the cycle following edge T+3 and low otherwise.
REQ-022 in_valid asserted in DRAIN or OUT is ignored; a new burst is accepted from IDLE only (the cycle after out_valid).
REQ-023 Accumulator and word counter clear on entry to LOAD_A; no residue from a previous burst.
REQ-024 Back-to-back bursts: first word may be presented in the cycle immediately after out_valid.

Reset
REQ-025 rst_n low forces state IDLE, counter 0, accumulator 0, pipeline registers 0, out_valid 0, out 0, asynchronously.
REQ-026 Reset mid-burst discards the partial burst; no out_valid is produced for it.
REQ-027 A buffer contents need not be reset (overwritten before use).

Structure
REQ-028 Shared package seq_dot_mac_pkg holds the state enum and the default DATA_W/N constants plus an OUT_W helper function.
REQ-029 One sub-module seq_dot_mac_abuf: N x DATA_W write-sequential, read-indexed buffer with forward/reverse read addressing.
REQ-030 Top holds FSM, counter, multiply and accumulate stages.

Verification (DATA_W=16, N=16)
REQ-031 Mode 0, A all 1, B=1..16, contiguous -> out=136, out_valid one cycle at T+3 edge.
REQ-032 Mode 0, A and B all -32768 -> out=17179869184 (2^34), no overflow.
REQ-033 A[i]=B[i]=i (0..15): mode 0 -> 1240; mode 1 -> 560.
REQ-034 REQ-031 stimulus with in_valid low every other cycle and in_mode toggling after word 0 -> out=136, latency measured from last word.
REQ-035 rst_n low 2 cycles after word 10, then full REQ-031 burst -> exactly one out_valid, out=136.
REQ-036 in_valid held high through DRAIN/OUT, then back-to-back second burst (mode 1, A[i]=B[i]=i) -> outputs 136 then 560, extra words ignored.
